// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-lane round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_LANES-1:0] onehot4(input logic [SEL_W-1:0] idx);
    onehot4 = '0;
    onehot4[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux4_dw.sv
// DW-bit wide 4:1 data multiplexer; lane k lives at in_data[k*DW +: DW].
module mux4_dw
  import mux4_arb_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic [NUM_LANES*DW-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [DW-1:0]           y
);

  assign y = in_data[sel*DW +: DW];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux channel with valid/ready output
// and a per-tenure beat cap that only applies while other lanes wait.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW        = 1,
  parameter int MAX_BEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_LANES-1:0]    req,
  input  logic [NUM_LANES*DW-1:0] in_data,
  input  logic                    out_ready,
  output logic [NUM_LANES-1:0]    grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic                    busy
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  arb_state_t           state, state_next;
  logic [NUM_LANES-1:0] grant_next;
  logic [SEL_W-1:0]     sel_next;
  logic [SEL_W-1:0]     ptr, ptr_next;
  logic [CW-1:0]        beat_cnt, cnt_next;
  logic [SEL_W-1:0]     winner;
  logic [SEL_W-1:0]     scan_idx;
  logic                 found;
  logic                 beat;
  logic                 others;
  logic                 release_now;
  logic [DW-1:0]        mux_y;

  mux4_dw #(.DW(DW)) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .y       (mux_y)
  );

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      scan_idx = ptr + SEL_W'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  assign busy      = (state == ST_GRANT);
  assign out_valid = busy && req[sel];
  assign out_data  = out_valid ? mux_y : '0;
  assign beat      = out_valid && out_ready;
  assign others    = |(req & ~onehot4(sel));
  assign release_now = !req[sel] || (beat && (beat_cnt == LAST_BEAT) && others);

  always_comb begin
    state_next = state;
    grant_next = grant;
    sel_next   = sel;
    ptr_next   = ptr;
    cnt_next   = beat_cnt;
    case (state)
      ST_IDLE: begin
        grant_next = '0;
        if (found) begin
          sel_next   = winner;
          grant_next = onehot4(winner);
          cnt_next   = '0;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_next = ST_IDLE;
          grant_next = '0;
          ptr_next   = sel + SEL_W'(1);
        end else if (beat) begin
          // A lone owner keeps the channel and simply restarts its tenure.
          cnt_next = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      sel      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      sel      <= sel_next;
      ptr      <= ptr_next;
      beat_cnt <= cnt_next;
    end
  end

endmodule
